// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory bus with a BUSY timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with the data port first.

// state | meaning
// IDLE  | no transaction; gnt outputs follow the requests combinationally
// BUSY  | latched request driven on mem_*, waiting for mem_ready or timeout
// RESP  | one-cycle rvalid (and err on timeout) to the owning port
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t                  state_q, state_d;
    logic                    owner_q;   // 1 = data port, 0 = fetch port
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    err_q;
    logic [15:0]             cnt_q;
    logic                    grant_if, grant_d;
    logic                    timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
    logic                    last_d_q;
`endif

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == IDLE) begin
            if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_d_q) grant_if = 1'b1;
                else          grant_d  = 1'b1;
`else
                grant_d = 1'b1;
`endif
            end else begin
                grant_if = if_req;
                grant_d  = d_req;
            end
        end
    end

    // Timeout fires on the cycle whose increment would bring the count to TIMEOUT.
    assign timeout_hit = (cnt_q + 16'd1) == TIMEOUT_CNT;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_if || grant_d) state_d = BUSY;
            BUSY:    if (mem_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_if || grant_d) begin
                        owner_q <= grant_d;
                        addr_q  <= grant_d ? d_addr : if_addr;
                        we_q    <= grant_d & d_we;
                        be_q    <= grant_d ? d_be : 4'hF;
                        wdata_q <= grant_d ? d_wdata : 32'h0;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        rdata_q <= we_q ? 32'h0 : mem_rdata;
                        err_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (timeout_hit) begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset)                      last_d_q <= 1'b0;
        else if (grant_if || grant_d)   last_d_q <= grant_d;
    end
`endif

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign busy      = state_q != IDLE;
    assign mem_req   = state_q == BUSY;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rvalid = (state_q == RESP) && !owner_q;
    assign d_rvalid  = (state_q == RESP) && owner_q;
    assign if_rdata  = if_rvalid ? rdata_q : 32'h0;
    assign d_rdata   = d_rvalid ? rdata_q : 32'h0;
    assign if_err    = if_rvalid & err_q;
    assign d_err     = d_rvalid & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then constrained-random traffic.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_rvalid, if_err;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic          mem_req, mem_we, mem_ready, busy;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one outstanding transaction, a pending response, and arbitration history.
    bit          model_on = 1'b0;
    bit          m_active = 1'b0, m_resp = 1'b0, m_port_d = 1'b0, m_last_d = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    bit          m_we = 1'b0, m_err = 1'b0;
    logic [3:0]  m_be = '0;
    int          m_waited = 0;
    bit          e_idle, w_if, w_d, rv_if, rv_d;

    always @(negedge clk) begin
        e_idle = !m_active && !m_resp;
        w_if = 1'b0;
        w_d  = 1'b0;
        if (e_idle) begin
            if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (m_last_d) w_if = 1'b1;
                else          w_d  = 1'b1;
`else
                w_d = 1'b1;
`endif
            end else begin
                w_if = if_req;
                w_d  = d_req;
            end
        end
        rv_if = m_resp && !m_port_d;
        rv_d  = m_resp && m_port_d;

        if (model_on) begin
            chk("busy", 32'(busy), 32'(!e_idle));
            chk("if_gnt", 32'(if_gnt), 32'(w_if));
            chk("d_gnt", 32'(d_gnt), 32'(w_d));
            chk("mem_req", 32'(mem_req), 32'(m_active));
            if (m_active) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", 32'(mem_we), 32'(m_we));
                chk("mem_be", 32'(mem_be), 32'(m_be));
                chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("if_rvalid", 32'(if_rvalid), 32'(rv_if));
            chk("d_rvalid", 32'(d_rvalid), 32'(rv_d));
            if (rv_if) begin
                chk("if_rdata", if_rdata, m_rdata);
                chk("if_err", 32'(if_err), 32'(m_err));
            end else chk("if_err_idle", 32'(if_err), 32'h0);
            if (rv_d) begin
                chk("d_rdata", d_rdata, m_rdata);
                chk("d_err", 32'(d_err), 32'(m_err));
            end else chk("d_err_idle", 32'(d_err), 32'h0);
        end

        if (reset) begin
            m_active = 1'b0;
            m_resp   = 1'b0;
            m_last_d = 1'b0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_active) begin
            if (mem_ready) begin
                m_rdata  = m_we ? 32'h0 : mem_rdata;
                m_err    = 1'b0;
                m_active = 1'b0;
                m_resp   = 1'b1;
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    m_rdata  = 32'h0;
                    m_err    = 1'b1;
                    m_active = 1'b0;
                    m_resp   = 1'b1;
                end
            end
        end else if (w_if || w_d) begin
            m_active = 1'b1;
            m_waited = 0;
            m_port_d = w_d;
            m_addr   = w_d ? d_addr : if_addr;
            m_we     = w_d && d_we;
            m_be     = w_d ? d_be : 4'hF;
            m_wdata  = w_d ? d_wdata : 32'h0;
            m_last_d = w_d;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        mem_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit got[4];
    bit exp_seq[4];
    int n_gnt;
    int busy_n;
    bit p_if, p_d;

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        cyc();
        cyc();
        model_on = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_rvalid", 32'({if_rvalid, d_rvalid, if_err, d_err}), 32'h0);
        chk("rst_rdata", if_rdata | d_rdata, 32'h0);
        reset = 1'b0;

        // Single data read completing in the first BUSY cycle.
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF; d_wdata = '0;
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        #2;
        chk("a_d_gnt", 32'(d_gnt), 32'h1);
        chk("a_if_gnt", 32'(if_gnt), 32'h0);
        chk("a_mem_req0", 32'(mem_req), 32'h0);
        cyc();
        d_req = 1'b0;
        #2;
        chk("a_mem_req1", 32'(mem_req), 32'h1);
        chk("a_mem_addr", mem_addr, 32'h100);
        chk("a_mem_we", 32'(mem_we), 32'h0);
        cyc();
        mem_ready = 1'b0;
        #2;
        chk("a_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("a_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("a_d_err", 32'(d_err), 32'h0);
        chk("a_if_rvalid", 32'(if_rvalid), 32'h0);
        cyc();
        #2;
        chk("a_busy_after", 32'(busy), 32'h0);

        // Both ports requesting continuously for four grants.
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'hF;
        mem_ready = 1'b1; mem_rdata = 32'h11112222;
        n_gnt = 0;
        for (int i = 0; i < 40 && n_gnt < 4; i++) begin
            #2;
            if (d_gnt) begin got[n_gnt] = 1'b1; n_gnt++; end
            else if (if_gnt) begin got[n_gnt] = 1'b0; n_gnt++; end
            cyc();
        end
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        chk("b_grant_count", 32'(n_gnt), 32'd4);
        for (int k = 0; k < 4; k++) chk("b_grant_is_d", 32'(got[k]), 32'(exp_seq[k]));
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) cyc();
        mem_ready = 1'b0;

        // Write with mem_ready arriving on the fourth BUSY cycle (the timeout boundary).
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'h12345678; d_addr = 32'hA5A50040;
        mem_rdata = 32'hCAFEF00D;
        #2;
        chk("c_d_gnt", 32'(d_gnt), 32'h1);
        cyc();
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            #2;
            chk("c_mem_req", 32'(mem_req), 32'h1);
            chk("c_mem_we", 32'(mem_we), 32'h1);
            chk("c_mem_be", 32'(mem_be), 32'h3);
            chk("c_mem_wdata", mem_wdata, 32'h12345678);
            chk("c_mem_addr", mem_addr, 32'hA5A50040);
            chk("c_no_rvalid", 32'(d_rvalid), 32'h0);
            cyc();
        end
        mem_ready = 1'b0;
        #2;
        chk("c_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("c_d_rdata", d_rdata, 32'h0);
        chk("c_d_err", 32'(d_err), 32'h0);

        // Fetch with memory never ready: times out after TIMEOUT BUSY cycles.
        do_reset();
        if_req = 1'b1; if_addr = 32'h2000; mem_rdata = 32'hFFFFFFFF;
        #2;
        chk("d_if_gnt", 32'(if_gnt), 32'h1);
        cyc();
        if_req = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (if_rvalid) break;
            if (mem_req) busy_n++;
            cyc();
        end
        chk("d_busy_cycles", 32'(busy_n), 32'd4);
        chk("d_if_rvalid", 32'(if_rvalid), 32'h1);
        chk("d_if_err", 32'(if_err), 32'h1);
        chk("d_if_rdata", if_rdata, 32'h0);
        chk("d_d_rvalid", 32'(d_rvalid), 32'h0);
        cyc();
        #2;
        chk("d_idle", 32'(busy), 32'h0);

        // Reset during the second BUSY cycle aborts the transaction.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        #2;
        chk("e_d_gnt", 32'(d_gnt), 32'h1);
        cyc();
        d_req = 1'b0;
        #2;
        chk("e_busy1", 32'(mem_req), 32'h1);
        cyc();
        reset = 1'b1; mem_ready = 1'b1;
        #2;
        chk("e_busy2", 32'(mem_req), 32'h1);
        cyc();
        reset = 1'b0; mem_ready = 1'b0;
        #2;
        chk("e_mem_req", 32'(mem_req), 32'h0);
        chk("e_busy", 32'(busy), 32'h0);
        chk("e_rvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
        cyc();
        #2;
        chk("e_rvalid_later", 32'({if_rvalid, d_rvalid}), 32'h0);
        cyc();

        // Random traffic; requesters hold their request until granted.
        p_if = 1'b0;
        p_d  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!p_if && $urandom_range(0, 1) == 1) begin
                p_if = 1'b1;
                if_addr = $urandom;
            end
            if (!p_d && $urandom_range(0, 1) == 1) begin
                p_d = 1'b1;
                d_we = 1'($urandom_range(0, 1));
                d_be = 4'($urandom);
                d_addr = $urandom;
                d_wdata = $urandom;
            end
            if_req = p_if;
            d_req = p_d;
            mem_ready = ($urandom_range(0, 9) < 4);
            mem_rdata = $urandom;
            #2;
            if (if_gnt && !reset) p_if = 1'b0;
            if (d_gnt && !reset) p_d = 1'b0;
            cyc();
        end

        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
